// File: rtl/lcd_keypad_ctrl_if.sv
// lcd_keypad_ctrl_if: board-side pins and key-event outputs of lcd_keypad_ctrl
// master (controller): senses keypadCol; drives keypadRow, LCMData/LCMEN/LCMRS/LCMRW,
//   key_valid, key_ascii, char_count, init_done
// slave (board/testbench): the mirror image
interface lcd_keypad_ctrl_if #(
  parameter int ROWS = 3,
  parameter int COLS = 4
);
  logic [COLS-1:0] keypadCol;
  logic [ROWS-1:0] keypadRow;
  logic [7:0] LCMData;
  logic LCMEN;
  logic LCMRS;
  logic LCMRW;
  logic key_valid;
  logic [7:0] key_ascii;
  logic [4:0] char_count;
  logic init_done;
  modport master (
    input keypadCol,
    output keypadRow, LCMData, LCMEN, LCMRS, LCMRW, key_valid, key_ascii, char_count, init_done
  );
  modport slave (
    output keypadCol,
    input keypadRow, LCMData, LCMEN, LCMRS, LCMRW, key_valid, key_ascii, char_count, init_done
  );
endinterface

// File: rtl/lcd_keypad_ctrl.sv
// lcd_keypad_ctrl: scans and debounces a keypad matrix, buffers characters, drives an HD44780 LCD
// Ports: clk; rst (async, active-low); io (lcd_keypad_ctrl_if.master) carrying the keypad
//   row/column pins, LCD bus (LCMData, LCMEN, LCMRS, LCMRW) and key_valid/key_ascii/char_count/init_done.
// Option: define KEYPAD_BACKSPACE_EN to turn the last key (k = ROWS*COLS-1) into backspace.
module lcd_keypad_ctrl #(
  parameter int ROWS = 3,
  parameter int COLS = 4,
  parameter int BUF_DEPTH = 16,
  parameter int SCAN_TICKS = 2097152,
  parameter int LCD_TICKS = 25000,
  parameter int DEBOUNCE = 2
) (
  input logic clk,
  input logic rst,
  lcd_keypad_ctrl_if.master io
);
  localparam int SW = $clog2(SCAN_TICKS + 1);
  localparam int LW = $clog2(LCD_TICKS + 1);
  localparam int RW = $clog2(ROWS);
  typedef enum logic [1:0] {IDLE, CAND, HELD} kstate_t;
  // init states run once; enum order is the slot order so most steps are state+1
  typedef enum logic [3:0] {WAIT, FUNC, DISP, CLR, CLRW, ENTRY, ADDR1, DATA1, ADDR2, DATA2} lstate_t;
  logic [SW-1:0] scan_cnt;
  logic [RW-1:0] row, hrow, hrow_n;
  logic sample, seen, accept, is_bs;
  logic [COLS-1:0] low;
  logic [4:0] col, key, hkey, hkey_n, ones;
  logic [2:0] cnt, cnt_n;
  logic [7:0] ascii, d1, l2;
  logic [7:0] chars [BUF_DEPTH];
  kstate_t ks, ks_n;
  lstate_t ls, ls_n;
  logic [LW-1:0] lcnt;
  logic [3:0] idx, idx_n;
  logic slot_end, stay, tens;
  logic [8:0] slot_n;
  assign sample = scan_cnt == SW'(SCAN_TICKS - 1);
  assign io.keypadRow = ~(ROWS'(1) << row);
  assign io.LCMRW = 1'b0;
  assign ascii = key < 5'd10 ? 8'h30 + {3'b0, key} : 8'h37 + {3'b0, key};
`ifdef KEYPAD_BACKSPACE_EN
  assign is_bs = key == 5'(ROWS * COLS - 1);
`else
  assign is_bs = 1'b0;
`endif
  // a sample counts only when exactly one column is pulled low
  always_comb begin
    low = ~io.keypadCol;
    col = '0;
    for (int i = 0; i < COLS; i++) if (low[i]) col = 5'(i);
    seen = low != '0 && (low & (low - 1'b1)) == '0;
    key = 5'(row) * 5'(COLS) + col;
  end
  // after the first sighting only visits of the candidate's own row matter
  always_comb begin
    ks_n = ks;
    hkey_n = hkey;
    hrow_n = hrow;
    cnt_n = cnt;
    accept = 1'b0;
    if (sample) begin
      if (ks == IDLE) begin
        if (seen) begin
          hkey_n = key;
          hrow_n = row;
          cnt_n = 3'd1;
          accept = DEBOUNCE == 1;
          ks_n = accept ? HELD : CAND;
        end
      end else if (row == hrow) begin
        if (!(seen && key == hkey)) ks_n = IDLE;
        else if (ks == CAND) begin
          cnt_n = cnt + 3'd1;
          accept = cnt_n == 3'(DEBOUNCE);
          ks_n = accept ? HELD : CAND;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ks <= IDLE;
      hkey <= '0;
      hrow <= '0;
      cnt <= '0;
    end else begin
      ks <= ks_n;
      hkey <= hkey_n;
      hrow <= hrow_n;
      cnt <= cnt_n;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      row <= '0;
      io.key_valid <= 1'b0;
      io.key_ascii <= 8'h20;
      io.char_count <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) chars[i] <= 8'h20;
    end else begin
      scan_cnt <= sample ? '0 : scan_cnt + 1'b1;
      if (sample) row <= row == RW'(ROWS - 1) ? '0 : row + 1'b1;
      io.key_valid <= accept;
      if (accept) begin
        io.key_ascii <= is_bs ? 8'h08 : ascii;
        if (!is_bs) begin
          chars[0] <= ascii;
          for (int i = 1; i < BUF_DEPTH; i++) chars[i] <= chars[i-1];
          if (io.char_count != 5'(BUF_DEPTH)) io.char_count <= io.char_count + 5'd1;
        end else if (io.char_count != '0) begin
          for (int i = 0; i < BUF_DEPTH - 1; i++) chars[i] <= chars[i+1];
          chars[BUF_DEPTH-1] <= 8'h20;
          io.char_count <= io.char_count - 5'd1;
        end
      end
    end
  end
  // next slot's state plus the RS/data it will present, latched at the slot boundary
  always_comb begin
    stay = (ls == DATA1 && idx != 4'(BUF_DEPTH - 1)) || (ls == DATA2 && idx != 4'd15);
    ls_n = stay ? ls : ls == DATA2 ? ADDR1 : lstate_t'(ls + 4'd1);
    idx_n = stay ? idx + 4'd1 : '0;
    d1 = 8'h20;
    for (int i = 0; i < BUF_DEPTH; i++) if (idx_n == 4'(i)) d1 = chars[i];
    tens = io.char_count >= 5'd10;
    ones = io.char_count - (tens ? 5'd10 : 5'd0);
    l2 = idx_n == 4'd0 ? 8'h4E : idx_n == 4'd1 ? 8'h3D : idx_n == 4'd2 ? (tens ? 8'h31 : 8'h30) :
         idx_n == 4'd3 ? 8'h30 + {3'b0, ones} : 8'h20;
    slot_n = ls_n == FUNC ? 9'h038 : ls_n == DISP ? 9'h00C : ls_n == CLR ? 9'h001 :
             ls_n == ENTRY ? 9'h006 : ls_n == ADDR1 ? 9'h080 : ls_n == ADDR2 ? 9'h0C0 :
             ls_n == DATA1 ? {1'b1, d1} : ls_n == DATA2 ? {1'b1, l2} : 9'h000;
  end
  assign slot_end = lcnt == LW'(LCD_TICKS - 1);
  assign io.LCMEN = ls != WAIT && ls != CLRW && lcnt < LW'(LCD_TICKS / 2);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ls <= WAIT;
      idx <= '0;
    end else if (slot_end) begin
      ls <= ls_n;
      idx <= idx_n;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lcnt <= '0;
      io.LCMData <= '0;
      io.LCMRS <= 1'b0;
      io.init_done <= 1'b0;
    end else begin
      lcnt <= slot_end ? '0 : lcnt + 1'b1;
      if (slot_end) begin
        io.LCMRS <= slot_n[8];
        io.LCMData <= slot_n[7:0];
        if (ls == ENTRY) io.init_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lcd_keypad_ctrl.sv
// tb_lcd_keypad_ctrl: directed checks of scan/debounce, buffer, and LCD command stream
module tb_lcd_keypad_ctrl;
  localparam int ROWS = 3, COLS = 4, BUF_DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0, bad = 0, pulses = 0, p = 0, n = 0;
  logic press_en = 1'b0;
  logic [1:0] press_row = '0;
  logic [COLS-1:0] press_mask = '0;
  logic prev_en = 1'b0;
  logic [8:0] cap[$];
  logic [7:0] l1 [BUF_DEPTH];
  logic [7:0] l2 [16];
  lcd_keypad_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus();
  lcd_keypad_ctrl #(.ROWS(ROWS), .COLS(COLS), .BUF_DEPTH(BUF_DEPTH), .SCAN_TICKS(4),
    .LCD_TICKS(8), .DEBOUNCE(2)) dut (.clk(clk), .rst(rst), .io(bus));
  always #5 clk = ~clk;
  always_comb bus.keypadCol = (press_en && !bus.keypadRow[press_row]) ? ~press_mask : '1;
  always @(negedge clk) begin
    if (bus.key_valid) pulses++;
    if (bus.LCMEN && !prev_en) cap.push_back({bus.LCMRS, bus.LCMData});
    prev_en = bus.LCMEN;
  end
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic press(input int r, input logic [COLS-1:0] m, input int scans);
    press_row = 2'(r);
    press_mask = m;
    press_en = 1'b1;
    repeat (scans * 12) @(negedge clk);
    press_en = 1'b0;
    repeat (24) @(negedge clk);
  endtask
  task automatic grab();
    int i0 = -1;
    int w = 0;
    cap.delete();
    while ((i0 < 0 || cap.size() < i0 + 22) && w < 800) begin
      @(negedge clk);
      w++;
      if (i0 < 0) foreach (cap[j]) if (i0 < 0 && cap[j] == 9'h080) i0 = j;
    end
    chk("refresh_timeout", 16'(w < 800), 16'd1);
    if (w >= 800) return;
    chk("addr2_cmd", 16'(cap[i0+5]), 16'h0C0);
    for (int j = 0; j < BUF_DEPTH; j++) l1[j] = cap[i0+1+j][8] ? cap[i0+1+j][7:0] : 8'hFF;
    for (int j = 0; j < 16; j++) l2[j] = cap[i0+6+j][8] ? cap[i0+6+j][7:0] : 8'hFF;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (!bus.LCMEN && n < 100) begin @(negedge clk); n++; end
    chk("en_seen", 16'(bus.LCMEN), 16'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_row", 16'(bus.keypadRow), 16'b110);
    chk("rst_en", 16'(bus.LCMEN), 16'd0);
    chk("rst_count", 16'(bus.char_count), 16'd0);
    chk("rst_ascii", 16'(bus.key_ascii), 16'h20);
    chk("rst_valid", 16'(bus.key_valid), 16'd0);
    chk("rst_data", {bus.LCMRW, bus.LCMRS, bus.LCMData}, 16'h0);
    chk("rst_init", 16'(bus.init_done), 16'd0);
    cap.delete();
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (cap.size() < 5 && n < 400) begin @(negedge clk); n++; end
    chk("init_timeout", 16'(cap.size() >= 5), 16'd1);
    if (cap.size() >= 5) begin
      chk("init_func", 16'(cap[0]), 16'h038);
      chk("init_disp", 16'(cap[1]), 16'h00C);
      chk("init_clr", 16'(cap[2]), 16'h001);
      chk("init_entry", 16'(cap[3]), 16'h006);
      chk("init_addr1", 16'(cap[4]), 16'h080);
    end
    chk("init_done", 16'(bus.init_done), 16'd1);
    p = pulses;
    press(0, 4'b0010, 3);
    chk("single_pulses", 16'(pulses - p), 16'd1);
    chk("single_ascii", 16'(bus.key_ascii), 16'h31);
    chk("single_count", 16'(bus.char_count), 16'd1);
    grab();
    chk("single_line1_0", 16'(l1[0]), 16'h31);
    chk("single_line1_1", 16'(l1[1]), 16'h20);
    chk("single_line2_3", 16'(l2[3]), 16'h31);
    p = pulses;
    press_row = 2'd1;
    press_mask = 4'b0100;
    n = 0;
    while (bus.keypadRow != 3'b101 && n < 20) begin @(negedge clk); n++; end
    press_en = 1'b1;
    while (bus.keypadRow == 3'b101 && n < 40) begin @(negedge clk); n++; end
    press_en = 1'b0;
    chk("bounce_sync", 16'(n < 40), 16'd1);
    repeat (36) @(negedge clk);
    chk("bounce_pulses", 16'(pulses - p), 16'd0);
    press(1, 4'b0100, 3);
    chk("repress_pulses", 16'(pulses - p), 16'd1);
    chk("repress_ascii", 16'(bus.key_ascii), 16'h36);
    chk("repress_count", 16'(bus.char_count), 16'd2);
    p = pulses;
    press(2, 4'b0011, 3);
    chk("multi_pulses", 16'(pulses - p), 16'd0);
    chk("multi_count", 16'(bus.char_count), 16'd2);
    p = pulses;
    press(0, 4'b0001, 3);
    press(0, 4'b0010, 3);
    press(0, 4'b0100, 3);
    press(0, 4'b1000, 3);
    press(1, 4'b0001, 3);
    chk("ovf_pulses", 16'(pulses - p), 16'd5);
    chk("ovf_count", 16'(bus.char_count), 16'd4);
    chk("ovf_ascii", 16'(bus.key_ascii), 16'h34);
    grab();
    chk("ovf_l1_0", 16'(l1[0]), 16'h34);
    chk("ovf_l1_1", 16'(l1[1]), 16'h33);
    chk("ovf_l1_2", 16'(l1[2]), 16'h32);
    chk("ovf_l1_3", 16'(l1[3]), 16'h31);
    chk("ovf_l2_n", {l2[0], l2[1]}, 16'h4E3D);
    chk("ovf_l2_num", {l2[2], l2[3]}, 16'h3034);
    chk("ovf_l2_pad", 16'(l2[15]), 16'h20);
`ifdef KEYPAD_BACKSPACE_EN
    p = pulses;
    for (int i = 0; i < 4; i++) press(2, 4'b1000, 3);
    chk("bs_pulses", 16'(pulses - p), 16'd4);
    chk("bs_empty_count", 16'(bus.char_count), 16'd0);
    press(2, 4'b1000, 3);
    chk("bs_floor_count", 16'(bus.char_count), 16'd0);
    chk("bs_floor_pulses", 16'(pulses - p), 16'd5);
    press(0, 4'b0001, 3);
    press(0, 4'b0010, 3);
    press(2, 4'b1000, 3);
    chk("bs_count", 16'(bus.char_count), 16'd1);
    chk("bs_ascii", 16'(bus.key_ascii), 16'h08);
    grab();
    chk("bs_l1_0", 16'(l1[0]), 16'h30);
    chk("bs_l1_1", 16'(l1[1]), 16'h20);
    chk("bs_l1_3", 16'(l1[3]), 16'h20);
`else
    p = pulses;
    press(2, 4'b1000, 3);
    chk("lastkey_pulses", 16'(pulses - p), 16'd1);
    chk("lastkey_ascii", 16'(bus.key_ascii), 16'h42);
    chk("lastkey_count", 16'(bus.char_count), 16'd4);
    grab();
    chk("lastkey_l1_0", 16'(l1[0]), 16'h42);
    chk("lastkey_l1_3", 16'(l1[3]), 16'h32);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst2_count", 16'(bus.char_count), 16'd0);
    chk("rst2_ascii", 16'(bus.key_ascii), 16'h20);
    chk("rst2_init", 16'(bus.init_done), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
